// File: rtl/bcp_pkg.sv
// Shared types and constants for the multi-channel BCP engine.
// Clause literals are packed as {used, neg, var}, with slot 0 in the least significant bits.
package bcp_pkg;

    localparam int unsigned DEF_VAR_W = 6;

    localparam logic [1:0] ST_UNASG = 2'b00;
    localparam logic [1:0] ST_TRUE  = 2'b01;
    localparam logic [1:0] ST_FALSE = 2'b10;

    typedef struct packed {
        logic                 used;
        logic                 neg;
        logic [DEF_VAR_W-1:0] var_id;
    } lit_t;

    typedef enum logic [1:0] {NONE, SAT, UNIT, CONFL} eval_t;

    typedef enum logic {RUN, CONF} state_t;

    function automatic int unsigned lit_w(input int unsigned var_w);
        return var_w + 2;
    endfunction

endpackage

// File: rtl/bcp_clause_eval.sv
// Combinational evaluation of one clause against the committed assignment table.
// It classifies the clause and reports the unit literal and the lowest-slot used variable.
module bcp_clause_eval
    import bcp_pkg::*;
#(
    parameter int unsigned NVARS = 64,
    parameter int unsigned VAR_W = $clog2(NVARS),
    parameter int unsigned LITS  = 4
) (
    input  logic [LITS*(VAR_W+2)-1:0] clause,
    input  logic [NVARS-1:0][1:0]     asg,
    output eval_t                     result,
    output logic [VAR_W-1:0]          unit_var,
    output logic                      unit_value,
    output logic [VAR_W-1:0]          first_var
);

    localparam int unsigned LW = lit_w(VAR_W);

    logic [LW-1:0] lit;
    logic [1:0]    st;
    logic          sat;
    logic          seen_unasg;
    logic          many_unasg;
    logic          found;

    always_comb begin
        lit        = '0;
        st         = ST_UNASG;
        sat        = 1'b0;
        seen_unasg = 1'b0;
        many_unasg = 1'b0;
        found      = 1'b0;
        unit_var   = '0;
        unit_value = 1'b0;
        first_var  = '0;
        for (int unsigned l = 0; l < LITS; l++) begin
            lit = clause[l*LW +: LW];
            st  = asg[lit[VAR_W-1:0]];
            if (lit[LW-1]) begin
                if (!found) begin
                    found     = 1'b1;
                    first_var = lit[VAR_W-1:0];
                end
                if (st == ST_UNASG) begin
                    if (seen_unasg) many_unasg = 1'b1;
                    seen_unasg = 1'b1;
                    unit_var   = lit[VAR_W-1:0];
                    unit_value = ~lit[LW-2];
                end else if ((st == ST_TRUE) != lit[LW-2]) begin
                    sat = 1'b1;
                end
            end
        end
        if (sat)              result = SAT;
        else if (!seen_unasg) result = CONFL;
        else if (!many_unasg) result = UNIT;
        else                  result = NONE;
    end

endmodule

// File: rtl/bcp_multi_engine.sv
// Multi-channel BCP engine: stages clause bundles, commits unit implications and decisions,
// tracks the first conflict, and queues every new assignment for the traversal engine.
module bcp_multi_engine
    import bcp_pkg::*;
#(
    parameter  int unsigned NVARS    = 64,
    parameter  int unsigned LITS     = 4,
    parameter  int unsigned CH       = 2,
    parameter  int unsigned IQ_DEPTH = 8,
    localparam int unsigned VAR_W    = $clog2(NVARS)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CLR,
    input  logic                         DEC_VALID,
    input  logic [VAR_W-1:0]             DEC_VAR,
    input  logic                         DEC_VALUE,
    output logic                         DEC_READY,
    input  logic                         CL_VALID,
    input  logic [CH*LITS*(VAR_W+2)-1:0] CL_DATA,
    input  logic [CH-1:0]                CL_MASK,
    output logic                         CL_READY,
    output logic                         IMP_VALID,
    output logic [VAR_W-1:0]             IMP_VAR,
    output logic                         IMP_VALUE,
    input  logic                         IMP_READY,
    input  logic [VAR_W-1:0]             Q_VAR,
    output logic [1:0]                   Q_STATE,
    output logic                         CONFLICT,
    output logic [VAR_W-1:0]             CONF_VAR,
    output logic [15:0]                  UNIT_CNT
);

    localparam int unsigned CW    = LITS * lit_w(VAR_W);
    localparam int unsigned PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(IQ_DEPTH + 1);

    state_t                  state, state_next;
    logic [NVARS-1:0][1:0]   asg;
    logic                    stage_valid;
    logic [CH*CW-1:0]        stage_data;
    logic [CH-1:0]           stage_mask;
    logic [VAR_W-1:0]        fifo_var [IQ_DEPTH];
    logic [IQ_DEPTH-1:0]     fifo_val;
    logic [PTR_W-1:0]        rd_ptr, wr_ptr, wr_next;
    logic [PTR_W-1:0]        waddr [CH];
    logic [CNT_W-1:0]        count, free_slots, push_n, n_commit;

    eval_t                   res  [CH];
    logic [VAR_W-1:0]        uvar [CH];
    logic [VAR_W-1:0]        fvar [CH];
    logic [CH-1:0]           uval, keep, commit;
    logic                    bundle_conf;
    logic [VAR_W-1:0]        bundle_conf_var;
    logic                    eval_en, dec_fire, dec_new, dec_conf, pop, accept;
    logic [1:0]              dec_st;
    logic [16:0]             cnt_sum;
    int unsigned             rank, off;

    for (genvar c = 0; c < CH; c++) begin : g_eval
        bcp_clause_eval #(.NVARS(NVARS), .VAR_W(VAR_W), .LITS(LITS)) u_eval (
            .clause     (stage_data[c*CW +: CW]),
            .asg        (asg),
            .result     (res[c]),
            .unit_var   (uvar[c]),
            .unit_value (uval[c]),
            .first_var  (fvar[c])
        );
    end

    assign free_slots = CNT_W'(IQ_DEPTH) - count;
    assign eval_en    = stage_valid && (state == RUN);
    assign accept     = CL_VALID && CL_READY;
    assign dec_fire   = DEC_VALID && DEC_READY;
    assign dec_st     = asg[DEC_VAR];
    assign dec_new    = dec_fire && (dec_st == ST_UNASG);
    assign dec_conf   = dec_fire && (dec_st != ST_UNASG) && (dec_st != {~DEC_VALUE, DEC_VALUE});
    assign pop        = IMP_READY && (count != '0);
    assign IMP_VALID  = (count != '0);
    assign IMP_VAR    = fifo_var[rd_ptr];
    assign IMP_VALUE  = fifo_val[rd_ptr];
    assign Q_STATE    = asg[Q_VAR];

    // Lower channels win: a later UNIT on an already-implied var is either a duplicate or a clash.
    always_comb begin
        keep            = '0;
        bundle_conf     = 1'b0;
        bundle_conf_var = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (eval_en && stage_mask[c]) begin
                if (res[c] == CONFL) begin
                    if (!bundle_conf) begin
                        bundle_conf     = 1'b1;
                        bundle_conf_var = fvar[c];
                    end
                end else if (res[c] == UNIT) begin
                    keep[c] = 1'b1;
                    for (int unsigned k = 0; k < c; k++) begin
                        if (stage_mask[k] && (res[k] == UNIT) && (uvar[k] == uvar[c])) begin
                            keep[c] = 1'b0;
                            if ((uval[k] != uval[c]) && !bundle_conf) begin
                                bundle_conf     = 1'b1;
                                bundle_conf_var = uvar[c];
                            end
                        end
                    end
                end
            end
        end
    end

    // Decisions and stage evaluation never share a cycle, so both push from wr_ptr.
    always_comb begin
        commit = '0;
        rank   = 0;
        off    = 0;
        for (int unsigned c = 0; c < CH; c++) begin
            commit[c] = keep[c] && !bundle_conf;
            off = 32'(wr_ptr) + rank;
            if (off >= IQ_DEPTH) off = off - IQ_DEPTH;
            waddr[c] = PTR_W'(off);
            if (commit[c]) rank = rank + 1;
        end
        n_commit = CNT_W'(rank);
        push_n   = n_commit + CNT_W'(dec_new);
        off      = 32'(wr_ptr) + 32'(push_n);
        if (off >= IQ_DEPTH) off = off - IQ_DEPTH;
        wr_next  = PTR_W'(off);
        cnt_sum  = 17'(UNIT_CNT) + 17'(n_commit);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= RUN;
        else if (CLR) state <= RUN;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        if ((state == RUN) && (dec_conf || bundle_conf)) state_next = CONF;
    end

    always_comb begin
        CONFLICT  = (state == CONF);
        DEC_READY = (state == RUN) && !stage_valid && (free_slots != '0);
        CL_READY  = (state == RUN) && !DEC_VALID &&
                    (32'(free_slots) >= CH + (stage_valid ? CH : 0));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            asg         <= '0;
            stage_valid <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            CONF_VAR    <= '0;
            UNIT_CNT    <= '0;
        end else if (CLR) begin
            asg         <= '0;
            stage_valid <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            CONF_VAR    <= '0;
            UNIT_CNT    <= '0;
        end else begin
            stage_valid <= accept;
            if (dec_new) asg[DEC_VAR] <= {~DEC_VALUE, DEC_VALUE};
            for (int unsigned c = 0; c < CH; c++) begin
                if (commit[c]) asg[uvar[c]] <= {~uval[c], uval[c]};
            end
            if (pop) rd_ptr <= (rd_ptr == PTR_W'(IQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            wr_ptr   <= wr_next;
            count    <= count + push_n - CNT_W'(pop);
            UNIT_CNT <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            if (dec_conf) CONF_VAR <= DEC_VAR;
            else if (bundle_conf) CONF_VAR <= bundle_conf_var;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            stage_data <= CL_DATA;
            stage_mask <= CL_MASK;
        end
        if (dec_new) begin
            fifo_var[wr_ptr] <= DEC_VAR;
            fifo_val[wr_ptr] <= DEC_VALUE;
        end
        for (int unsigned c = 0; c < CH; c++) begin
            if (commit[c]) begin
                fifo_var[waddr[c]] <= uvar[c];
                fifo_val[waddr[c]] <= uval[c];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST && !CLR) begin
            assert (32'(count) + 32'(push_n) - 32'(pop) <= IQ_DEPTH);
        end
    end

endmodule

// File: doc/bcp_multi_engine.md
Name: bcp_multi_engine

Overview:
- Parametrised successor of the single-channel check/traversal pairing: evaluates CH clauses per cycle against an internal variable-assignment table.
- Detects unit clauses and conflicts, and commits implied assignments.
- Queues every new assignment (decision or implication) for the traversal engine to fetch the next watch list.
- Sits between the traversal engine (clause source, implication sink) and the decision/backtrack controller.

Parameters:
- NVARS, 64, number of variables; VAR_W = $clog2(NVARS).
- LITS, 4, literal slots per clause.
- CH, 2, clauses accepted per bundle.
- IQ_DEPTH, 8, implication FIFO entries; must be >= CH+1.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- CLR  in  1  synchronous full backtrack (clear all state).
- DEC_VALID  in  1  decision request.
- DEC_VAR  in  VAR_W  decision variable.
- DEC_VALUE  in  1  decision value.
- DEC_READY  out  1  decision accepted when high with DEC_VALID.
- CL_VALID  in  1  clause bundle valid.
- CL_DATA  in  CH*LITS*(VAR_W+2)  clauses. Channel c occupies the bits starting at c*LITS*(VAR_W+2). Each literal is {used, neg, var}.
- CL_MASK  in  CH  per-channel clause valid.
- CL_READY  out  1  bundle accepted when high with CL_VALID.
- IMP_VALID  out  1  implication FIFO non-empty.
- IMP_VAR  out  VAR_W  head variable.
- IMP_VALUE  out  1  head value.
- IMP_READY  in  1  pop.
- Q_VAR  in  VAR_W  assignment query.
- Q_STATE  out  2  combinational assignment state of Q_VAR.
- CONFLICT  out  1  sticky conflict flag.
- CONF_VAR  out  VAR_W  variable implicated in the first conflict.
- UNIT_CNT  out  16  saturating count of committed implications.

Behaviour:
- Reset values (RST low, asynchronous):
  - every assignment is UNASG; FIFO empty; stage empty; state RUN.
  - CONFLICT=0, CONF_VAR=0, UNIT_CNT=0.
  - DEC_READY and CL_READY follow their equations from the reset state.
- CLR (sync, highest priority): same effect as reset, taking effect at the clock edge. Any in-flight bundle is discarded.
- Assignment encoding: UNASG=00, TRUE=01, FALSE=10; 11 is never written.
- Literal value:
  - used=0: ignored.
  - otherwise: var state XOR neg; UNASG stays UNASG.
  - The implied value of a literal is ~neg.
- States:
  - RUN to CONF on any conflict.
  - CONF to RUN only on CLR.
  - In CONF: DEC_READY=0 and CL_READY=0; the FIFO still drains.
- Stage: an accepted bundle is registered into the stage (1 cycle). It is evaluated in the following cycle from the registered assignment table, and its results commit at the end of that cycle. A bundle accepted in the same cycle is evaluated next cycle and sees those commits.
- Per-channel evaluation (masked channels are ignored):
  - SAT: any literal TRUE.
  - CONFL: not SAT and 0 UNASG literals.
  - UNIT: not SAT and exactly 1 UNASG literal.
  - otherwise no action.
- Intra-bundle resolution, in ascending channel order:
  - a UNIT whose var equals that of an earlier UNIT with the same value is dropped;
  - with the opposite value, it is a conflict on that var.
  - Surviving UNITs write the table, push to the FIFO in channel order and increment UNIT_CNT (saturating at 16'hFFFF).
- Conflict in a bundle:
  - no UNIT of that bundle commits;
  - CONFLICT set; CONF_VAR = var of the lowest conflicting channel. For CONFL this is the lowest-slot used literal; for a clash it is the clashing var.
- FREE = IQ_DEPTH - occupancy.
- CL_READY = RUN && !DEC_VALID && (FREE - (stage_valid ? CH : 0)) >= CH.
- DEC_READY = RUN && !stage_valid && FREE >= 1. A pending decision has priority and blocks clause acceptance.
- Decision:
  - var UNASG: write and push.
  - already assigned with the same value: no-op, no push.
  - already assigned with the opposite value: conflict, CONF_VAR = DEC_VAR.
- FIFO:
  - a pop and pushes in the same cycle are legal;
  - overflow is impossible by construction; an assertion checks it.
  - Pop when empty is ignored.
- Q_STATE reflects committed table contents only.

Decomposition:
- Package bcp_pkg: assign-state constants, lit_t struct {used, neg, var}, eval-result enum {NONE, SAT, UNIT, CONFL}, and the LIT_W helper. Parameterised by a VAR_W localparam default; module parameters override.
- Sub-module bcp_clause_eval (combinational): takes one clause plus the assignment table and returns result, unit var and unit value. It is instantiated CH times via generate.
- The FIFO stays inline.

Test Plan:
- Reset/CLR: assert RST low mid-bundle -> all outputs at reset values, Q_STATE(any)=00. Repeat with CLR -> identical.
- Decision then unit:
  - DEC var3=1, then clause {¬3, 5} on channel 0 -> IMP sequence (3,1),(5,1); UNIT_CNT=1; Q_STATE(5)=01.
- Dual-channel dedupe/clash:
  - vars 1,2 =1; ch0 {¬1, 7}, ch1 {¬2, 7} -> single push (7,1), UNIT_CNT=1.
  - change ch1 to {¬2, ¬7} -> CONFLICT=1, CONF_VAR=7, var7 stays UNASG.
- Clause conflict: vars 4,6 =0; clause {4, 6} -> CONFLICT=1 next cycle, CONF_VAR=4, CL_READY=0 until CLR.
- Backpressure: IQ_DEPTH=8, IMP_READY=0, stream all-unit bundles -> CL_READY drops once FREE<CH (accounting for the stage); no push lost; FIFO holds 8 in order.
- Decision contention: DEC_VALID and CL_VALID together with the stage empty -> decision accepted first, CL_READY=0 that cycle. Repeated decision with the same value -> no push; with the opposite value -> CONFLICT.
